// File: rtl/jtopll_mix.sv
// Output mixer for the OPLL/OPL operator stream: accumulates carrier/additive slots per frame,
// then scales, saturates and strobes one sample per frame with clip reporting.
module jtopll_mix #(
  parameter int CH   = 9,
  parameter int OPW  = 13,
  parameter int OUTW = 16,
  parameter int GAIN = 2,
  parameter int RHY  = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cenop,
  input  logic                   zero,
  input  logic signed [OPW-1:0]  op_result,
  input  logic                   op,
  input  logic                   con,
  input  logic                   rhy_en,
  input  logic [CH-1:0]          mute,
  output logic signed [OUTW-1:0] snd,
  output logic                   sample,
  output logic                   clip
);

  localparam int SLOTS = 2 * CH;
  localparam int SBW   = $clog2(SLOTS);
  localparam int AW    = OPW + $clog2(SLOTS) + 2;
  // Scaled sum is kept wide enough that the GAIN shift can never wrap before saturation.
  localparam int SW    = (AW + 4 > OUTW + 1) ? AW + 4 : OUTW + 1;
  localparam logic [SBW-1:0] LAST = SBW'(SLOTS - 1);
  localparam bit RHY_ON = (RHY != 0);
  localparam logic signed [SW-1:0] MAXV = {{(SW-OUTW+1){1'b0}}, {(OUTW-1){1'b1}}};
  localparam logic signed [SW-1:0] MINV = {{(SW-OUTW+1){1'b1}}, {(OUTW-1){1'b0}}};

  // Per-slot static decode: owning channel's mute bit and rhythm-channel membership.
  logic [SLOTS-1:0] slot_mute;
  logic [SLOTS-1:0] slot_rhy_keep;
  logic [SLOTS-1:0] slot_rhy_dbl;

  genvar gi;
  generate
    for (gi = 0; gi < SLOTS; gi++) begin : g_slot
      localparam bit KEEP = ((gi / 2) >= (CH - 2));
      localparam bit DBL  = ((gi / 2) >= (CH - 3));
      assign slot_mute[gi]     = mute[gi/2];
      assign slot_rhy_keep[gi] = KEEP;
      assign slot_rhy_dbl[gi]  = DBL;
    end
  endgenerate

  // s_reg is the index the next non-zero slot will take; full_reg marks the last slot consumed.
  logic [SBW-1:0]        s_reg;
  logic                  full_reg;
  logic signed [AW-1:0]  acc_reg;
  logic                  valid_reg;

  logic [SBW-1:0]        cur_s;
  logic                  drop;
  logic                  rhy_act;
  logic                  keep;
  logic signed [AW-1:0]  v_ext;
  logic signed [AW-1:0]  contrib;
  logic signed [SW-1:0]  acc_ext;
  logic signed [SW-1:0]  scaled;
  logic signed [OUTW-1:0] sat_val;
  logic                  sat_hit;

  always_comb begin
    cur_s   = zero ? '0 : s_reg;
    drop    = !zero && full_reg;
    rhy_act = RHY_ON && rhy_en;
    keep    = !slot_mute[cur_s] && (op || con || (rhy_act && slot_rhy_keep[cur_s]));
    v_ext   = {{(AW-OPW){op_result[OPW-1]}}, op_result};
    contrib = '0;
    if (keep && !drop) begin
      contrib = (rhy_act && slot_rhy_dbl[cur_s]) ? (v_ext <<< 1) : v_ext;
    end
  end

  always_comb begin
    acc_ext = {{(SW-AW){acc_reg[AW-1]}}, acc_reg};
    scaled  = acc_ext <<< GAIN;
    sat_hit = 1'b0;
    sat_val = scaled[OUTW-1:0];
    if (scaled > MAXV) begin
      sat_val = MAXV[OUTW-1:0];
      sat_hit = 1'b1;
    end else if (scaled < MINV) begin
      sat_val = MINV[OUTW-1:0];
      sat_hit = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_reg     <= '0;
      full_reg  <= 1'b0;
      acc_reg   <= '0;
      valid_reg <= 1'b0;
      snd       <= '0;
      sample    <= 1'b0;
      clip      <= 1'b0;
    end else begin
      sample <= 1'b0;
      if (cenop) begin
        if (zero) begin
          acc_reg   <= contrib;
          valid_reg <= 1'b1;
          // The first frame start after reset has no complete frame behind it.
          if (valid_reg) begin
            snd    <= sat_val;
            clip   <= sat_hit;
            sample <= 1'b1;
          end
        end else if (!drop) begin
          acc_reg <= acc_reg + contrib;
        end
        if (!drop) begin
          if (cur_s == LAST) begin
            full_reg <= 1'b1;
          end else begin
            s_reg    <= cur_s + 1'b1;
            full_reg <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_jtopll_mix.sv
// Directed bench for jtopll_mix: frames of slots are driven, each frame's expected
// sample goes through a scoreboard queue and is checked when the strobe appears.
module tb_jtopll_mix;

  logic clk = 1'b0;
  logic rst_n;
  logic cenop;
  logic zero;
  logic signed [12:0] op_result;
  logic op;
  logic con;
  logic rhy_en;
  logic [8:0] mute;
  logic signed [15:0] snd;
  logic sample;
  logic clip;

  int checks = 0;
  int errors = 0;

  logic [16:0] sb[$];
  bit pend_valid = 0;
  logic signed [15:0] pend_snd = '0;
  logic pend_clip = 1'b0;
  logic signed [15:0] last_snd = '0;

  always #5 clk = ~clk;

  jtopll_mix #(
    .CH(9), .OPW(13), .OUTW(16), .GAIN(2), .RHY(1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .cenop(cenop),
    .zero(zero),
    .op_result(op_result),
    .op(op),
    .con(con),
    .rhy_en(rhy_en),
    .mute(mute),
    .snd(snd),
    .sample(sample),
    .clip(clip)
  );

  task automatic slot(input int v, input logic o, input logic c, input logic z,
                      input logic r, input logic [8:0] m, input bit idle);
    logic exp_strobe;
    logic [16:0] e;
    logic signed [15:0] es;
    cenop = 1'b1; zero = z; op_result = 13'(v); op = o; con = c; rhy_en = r; mute = m;
    exp_strobe = 1'b0;
    if (z && pend_valid) begin
      sb.push_back({pend_clip, pend_snd});
      exp_strobe = 1'b1;
    end
    @(posedge clk); #1;
    checks++;
    assert (sample === exp_strobe) else begin
      errors++;
      $error("FAIL sample_strobe: observed %0b expected %0b", sample, exp_strobe);
    end
    if (exp_strobe) begin
      e = sb.pop_front();
      es = e[15:0];
      checks++;
      assert (snd === es) else begin
        errors++;
        $error("FAIL snd: observed %0d expected %0d", snd, es);
      end
      checks++;
      assert (clip === e[16]) else begin
        errors++;
        $error("FAIL clip: observed %0b expected %0b", clip, e[16]);
      end
      last_snd = es;
    end
    if (idle) begin
      // Garbage on every input while cenop is low must be ignored entirely.
      cenop = 1'b0; zero = 1'b1; op_result = 13'sd3000; op = 1'b1; con = 1'b1;
      @(posedge clk); #1;
      checks++;
      assert (sample === 1'b0) else begin
        errors++;
        $error("FAIL idle_sample: observed %0b expected 0", sample);
      end
      checks++;
      assert (snd === last_snd) else begin
        errors++;
        $error("FAIL idle_hold: observed %0d expected %0d", snd, last_snd);
      end
    end
  endtask

  task automatic run_frame(input int n, input int v, input logic c, input logic r,
                           input logic [8:0] m, input bit idle, input int es, input logic ec);
    for (int i = 0; i < n; i++) begin
      slot(v, (i % 2) == 1, c, i == 0, r, m, idle);
    end
    pend_snd = 16'(es);
    pend_clip = ec;
    pend_valid = 1;
  endtask

  initial begin
    rst_n = 1'b1; cenop = 1'b0; zero = 1'b0; op_result = '0;
    op = 1'b0; con = 1'b0; rhy_en = 1'b0; mute = '0;
    #3 rst_n = 1'b0;
    @(negedge clk);
    checks++;
    assert (snd === 16'sd0) else begin errors++; $error("FAIL reset_snd: observed %0d expected 0", snd); end
    checks++;
    assert (sample === 1'b0) else begin errors++; $error("FAIL reset_sample: observed %0b expected 0", sample); end
    checks++;
    assert (clip === 1'b0) else begin errors++; $error("FAIL reset_clip: observed %0b expected 0", clip); end
    @(negedge clk);
    rst_n = 1'b1;

    run_frame(18,   100, 1'b0, 1'b0, 9'h000, 0,   3600, 1'b0);  // carriers only
    run_frame(18,    10, 1'b1, 1'b0, 9'h000, 0,    720, 1'b0);  // all additive
    run_frame(18,    10, 1'b1, 1'b0, 9'h001, 0,    640, 1'b0);  // channel 0 muted
    run_frame(18,    10, 1'b0, 1'b1, 9'h000, 0,    640, 1'b0);  // rhythm weighting
    run_frame(18,  4095, 1'b1, 1'b0, 9'h000, 0,  32767, 1'b1);
    run_frame(18, -4096, 1'b1, 1'b0, 9'h000, 0, -32768, 1'b1);
    run_frame(18,     0, 1'b1, 1'b0, 9'h000, 0,      0, 1'b0);
    run_frame(5,    100, 1'b0, 1'b0, 9'h000, 0,    800, 1'b0);  // short frame
    run_frame(25,   100, 1'b1, 1'b0, 9'h000, 0,   7200, 1'b0);  // long frame
    run_frame(18,    50, 1'b0, 1'b0, 9'h000, 1,   1800, 1'b0);  // cenop gaps
    run_frame(7,    100, 1'b1, 1'b0, 9'h000, 0,      0, 1'b0);  // interrupted

    #2 rst_n = 1'b0;
    cenop = 1'b0;
    pend_valid = 0;
    #1;
    checks++;
    assert (snd === 16'sd0) else begin errors++; $error("FAIL async_snd: observed %0d expected 0", snd); end
    checks++;
    assert (sample === 1'b0) else begin errors++; $error("FAIL async_sample: observed %0b expected 0", sample); end
    checks++;
    assert (clip === 1'b0) else begin errors++; $error("FAIL async_clip: observed %0b expected 0", clip); end
    @(negedge clk);
    rst_n = 1'b1;

    run_frame(18, 20, 1'b1, 1'b0, 9'h000, 0, 1440, 1'b0);
    run_frame(18, 30, 1'b0, 1'b0, 9'h000, 0, 1080, 1'b0);
    slot(0, 1'b0, 1'b0, 1'b1, 1'b0, 9'h000, 0);
    cenop = 1'b0;
    zero = 1'b0;

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain: observed %0d left expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/jtopll_mix.md
# jtopll_mix

Parametrised output mixer for the OPLL/OPL family. It replaces the fixed 9-channel, 13-bit accumulate stage at the end of the operator pipeline. The block consumes the serial per-slot operator stream and produces a saturated, gain-scaled, frame-rate sample with a strobe. It adds channel count, output width, per-channel mute, rhythm-mode weighting and clip reporting.

## Interface

Parameters:
- `CH`, 9: number of melodic channels; slots per frame = 2*CH.
- `OPW`, 13: width of signed operator result.
- `OUTW`, 16: width of signed output sample.
- `GAIN`, 2: left shift applied to frame sum before saturation (0..4).
- `RHY`, 1: 1 enables rhythm-mode handling of the last three channels.

Ports:
- `clk`, in, 1: system clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `cenop`, in, 1: operator clock enable; one slot is delivered per cenop cycle.
- `zero`, in, 1: first slot of frame, qualified by cenop.
- `op_result`, in, OPW signed: operator output for the current slot.
- `op`, in, 1: 1 = carrier, 0 = modulator.
- `con`, in, 1: connection bit; 1 = modulator is additive (output-contributing).
- `rhy_en`, in, 1: rhythm mode active; ignored when RHY=0.
- `mute`, in, CH: per-channel mute mask; bit n silences channel n.
- `snd`, out, OUTW signed: mixed sample.
- `sample`, out, 1: one-clk strobe when `snd` updates.
- `clip`, out, 1: saturation occurred in the frame now on `snd`.

## Operation

- Slot counter `s` runs 0..2*CH-1. Channel = s>>1.
- `zero` with `cenop` forces s=0 for the current slot.
- Otherwise `s` increments on each cenop.
- `s` holds at 2*CH-1; extra slots before `zero` are ignored and contribute nothing.
- Contribution rule per slot, evaluated on `op`, `con`, `rhy_en`, `mute` of that same slot. A slot contributes its value v when:
  - the channel is not muted, and
  - `op`=1, or `con`=1, or (RHY && `rhy_en` && channel >= CH-2).
- Rhythm weighting: with RHY && `rhy_en` and channel >= CH-3, the contribution is v<<1.
- Accumulator is signed, width OPW+clog2(2*CH)+2. No internal overflow is possible.
- Frame close, on cenop && `zero`:
  - The running sum of the previous frame is shifted left by GAIN, saturated to OUTW, and registered to `snd`.
  - `clip` is set if saturation occurred.
  - The accumulator restarts with the current slot's contribution.
- Saturation bounds: +(2^(OUTW-1)-1) and -(2^(OUTW-1)).
- Validity: the first `zero` after reset only starts accumulation. It does not update `snd` and does not pulse `sample`. Every later `zero` closes a frame.
- `mute`/`rhy_en` changes take effect from the next slot. There is no frame-boundary buffering.

## Timing

- Reset values: `snd`=0, `sample`=0, `clip`=0, accumulator=0, s=0, valid=0.
- Reset is asynchronous and can hit mid-frame. The partial sum is discarded and the next `zero` is treated as first-after-reset.
- Accumulate: 1 register stage. The slot sampled at cenop edge k is in the accumulator after edge k.
- Output latency: `snd`, `clip` and `sample` change on the clk edge where cenop && `zero` is sampled.
- `sample` is high exactly one clk cycle, even when cenop is held high continuously.
- `snd` and `clip` hold between strobes.
- No handshake: downstream must capture on `sample`.
- With cenop=0, all state is frozen; `sample` returns to 0 on the next clk.
- Short frame (`zero` early): closes with a partial sum, normal strobe.
- Long frame: excess slots are dropped as above.

## Test plan

- **Reset/first frame:** `rst_n` low, then run one frame with all op_result=100, op=1 → no `sample` pulse at the first `zero`. At the second `zero`, `sample`=1 for 1 clk, `snd`=9*100*4=3600, `clip`=0 (CH=9, GAIN=2; modulators excluded, con=0).
- **Connection/mute:**
  - con=1 on all slots, op_result=10 → `snd`=18*10*4=720.
  - Same with `mute`=9'h001 → `snd`=640.
- **Rhythm:** `rhy_en`=1, con=0, op_result=10 → `snd`=4*(6*10 + 2*10 + 4*20)=640.
- **Saturation:** OUTW=16, op_result=+4095 on all slots, con=1 → `snd`=32767, `clip`=1. All -4096 → `snd`=-32768, `clip`=1. Next frame at 0 → `snd`=0, `clip`=0.
- **Irregular frames:**
  - `zero` after 5 slots of 100 (op=1 on slots 1, 3) → `snd`=800.
  - 25 slots without `zero` → only the first 18 slots are summed.
- **Async reset mid-frame:** pulse `rst_n` low at slot 7 → `snd`=0 immediately. The next `zero` gives no strobe; the strobe returns at the following `zero`.
